// File: rtl/branch_predictor_btb_if.sv
// Fetch/EX-side bundle for the branch target buffer: same-cycle lookup,
// resolved-outcome training, flush and performance counter readout.
interface branch_predictor_btb_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  lookup_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             flush;
  logic             update_valid;
  logic [XLEN-1:0]  update_pc;
  logic             update_taken;
  logic [XLEN-1:0]  update_target;
  logic             update_is_jump;
  logic             update_mispredict;
  logic [CNT_W-1:0] perf_updates;
  logic [CNT_W-1:0] perf_mispredicts;

  modport master (
    output lookup_pc, flush, update_valid, update_pc, update_taken,
           update_target, update_is_jump, update_mispredict,
    input  pred_hit, pred_taken, pred_target, perf_updates, perf_mispredicts
  );

  modport slave (
    input  lookup_pc, flush, update_valid, update_pc, update_taken,
           update_target, update_is_jump, update_mispredict,
    output pred_hit, pred_taken, pred_target, perf_updates, perf_mispredicts
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational; training lands on the next clock edge.
module branch_predictor_btb #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 16
) (
  input logic                  clk,
  input logic                  reset,
  branch_predictor_btb_if.slave bus
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

  logic [ENTRIES-1:0]  valid_q;
  logic [TW-1:0]       tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [CNT_W-1:0]    perf_updates_q;
  logic [CNT_W-1:0]    perf_mispredicts_q;

  logic [IW-1:0]       lk_idx;
  logic [TW-1:0]       lk_tag;
  logic                lk_hit;
  logic                lk_taken;

  logic [IW-1:0]       up_idx;
  logic [TW-1:0]       up_tag;
  logic                up_hit;
  logic                wr_en;
  logic [CTR_BITS-1:0] wr_ctr;
  logic [XLEN-1:0]     wr_target;

  // Lookup reads the pre-update table contents; there is no write bypass.
  always_comb begin
    lk_idx   = bus.lookup_pc[IW+1:2];
    lk_tag   = bus.lookup_pc[XLEN-1:IW+2];
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
  end

  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_taken;
  assign bus.pred_target = lk_taken ? target_q[lk_idx] : bus.lookup_pc + XLEN'(4);

  always_comb begin
    up_idx    = bus.update_pc[IW+1:2];
    up_tag    = bus.update_pc[XLEN-1:IW+2];
    up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    wr_en     = 1'b0;
    wr_ctr    = ctr_q[up_idx];
    wr_target = target_q[up_idx];
    if (bus.update_valid && !bus.flush) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (bus.update_is_jump) begin
          wr_ctr    = CTR_MAX;
          wr_target = bus.update_target;
        end else if (bus.update_taken) begin
          wr_ctr    = (ctr_q[up_idx] == CTR_MAX) ? CTR_MAX : ctr_q[up_idx] + CTR_BITS'(1);
          wr_target = bus.update_target;
        end else begin
          wr_ctr    = (ctr_q[up_idx] == '0) ? '0 : ctr_q[up_idx] - CTR_BITS'(1);
        end
      end else if (bus.update_taken || bus.update_is_jump) begin
        // Miss allocation simply evicts whatever occupies the slot.
        wr_en     = 1'b1;
        wr_ctr    = bus.update_is_jump ? CTR_MAX : CTR_WEAK;
        wr_target = bus.update_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (bus.flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[up_idx]  <= 1'b1;
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= wr_target;
      ctr_q[up_idx]    <= wr_ctr;
    end
  end

  // Perf counters see every update, including ones discarded by a flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_updates_q     <= '0;
      perf_mispredicts_q <= '0;
    end else if (bus.update_valid) begin
      if (perf_updates_q != '1)
        perf_updates_q <= perf_updates_q + CNT_W'(1);
      if (bus.update_mispredict && (perf_mispredicts_q != '1))
        perf_mispredicts_q <= perf_mispredicts_q + CNT_W'(1);
    end
  end

  assign bus.perf_updates     = perf_updates_q;
  assign bus.perf_mispredicts = perf_mispredicts_q;
endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters.
- Sits beside PC/instruction_mem in the fetch stage. Given the current PC, it supplies a predicted next PC in the same cycle.
- The EX stage trains it with resolved branch and jump outcomes, so fetch can redirect without waiting for the EX-stage PC mux.
- Includes a synchronous table flush and saturating performance counters.

Parameters:
- XLEN, 32, address/data width
- ENTRIES, 16, number of BTB entries; power of two, 2..256
- CTR_BITS, 2, width of each direction counter, 1..4
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- lookup_pc  in  XLEN  fetch-stage PC
- pred_hit  out  1  lookup_pc matches a valid entry
- pred_taken  out  1  predict taken
- pred_target  out  XLEN  predicted next PC
- flush  in  1  invalidate all entries next edge
- update_valid  in  1  resolved control-flow instruction this cycle
- update_pc  in  XLEN  PC of resolved instruction
- update_taken  in  1  actual outcome
- update_target  in  XLEN  actual target
- update_is_jump  in  1  unconditional (jal/jalr)
- update_mispredict  in  1  fetch prediction was wrong
- perf_updates  out  CNT_W  count of accepted updates
- perf_mispredicts  out  CNT_W  count of mispredicts

Behaviour:
Field layout
- IW = log2(ENTRIES).
- index = pc[IW+1:2].
- tag = pc[XLEN-1:IW+2].
- pc[1:0] is ignored.

Storage
- Per entry: valid, tag, target (XLEN), counter (CTR_BITS).
- All state is in registers; no RAM macro.

Lookup (combinational, zero latency)
- pred_hit = valid[idx] && tag[idx] == lookup tag.
- pred_taken = pred_hit && counter[idx] MSB.
- pred_target = target[idx] if pred_taken, else lookup_pc + 4 (mod 2^XLEN).

Update (registered, one-cycle latency; visible to lookup on the cycle after the edge)
- Hit, conditional branch: counter increments if taken, decrements if not. Saturates at 0 and at 2^CTR_BITS-1. If taken, target <= update_target.
- Hit, jump: counter <= max; target <= update_target.
- Miss and (taken or jump): allocate, overwriting any occupant (direct-mapped, no replacement policy). valid <= 1, tag and target written. Counter <= max for a jump, else weakly taken = 2^(CTR_BITS-1).
- Miss and not taken, not jump: no table change.

Simultaneous events
- Lookup and update to the same index in one cycle: lookup returns pre-update contents (no bypass).
- flush and update_valid together: flush wins. All valid <= 0 and the update is discarded. Counters, tags, targets are untouched by flush. perf counters still count the update.

Performance counters
- perf_updates increments on each update_valid cycle.
- perf_mispredicts increments on update_valid && update_mispredict.
- update_mispredict is ignored when update_valid = 0.
- Both saturate at 2^CNT_W-1 (no wrap).

Reset
- reset = 0 at an edge clears every valid, counter (to 0), tag and target, and both perf counters.
- Updates presented in a reset cycle are dropped.
- Outputs during/after reset: pred_hit = 0, pred_taken = 0, pred_target = lookup_pc + 4, perf_* = 0.
- Reset mid-training discards all learned state; the first post-reset lookup misses.

Test Plan:
- Defaults (ENTRIES=16, CTR_BITS=2). Reset, then lookup 0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44; perf_*=0.
- Update pc=0x40, taken, target=0x100 -> next cycle lookup 0x40: hit=1, taken=1, target=0x100, counter=2. Repeat taken twice: counter saturates at 3. Three not-taken updates: counter 2,1,0, pred_taken=0, pred_target=0x44.
- Alias: train 0x40 (index 0, tag 1), then update 0x80 taken, target 0x200 -> lookup 0x40 misses; lookup 0x80 hits with target 0x200. Not-taken update to a missing pc 0xC0 leaves the table unchanged.
- Jump update pc=0x10, target=0x300, update_is_jump=1 -> counter=3. Same cycle as the update, lookup 0x10 still misses (no bypass); next cycle it hits.
- Assert flush together with an update to 0x20 -> all lookups miss next cycle, perf_updates increments. Drive reset=0 mid-stream -> perf_* return to 0 and an update presented in the reset cycle is not learned.
- CNT_W=4: 20 update_valid cycles with update_mispredict=1 -> perf_updates and perf_mispredicts hold at 15.
